// File: rtl/spi_pkg.sv
// Shared types and default timing for the 16-bit SPI master.
package spi_pkg;

   localparam int SPI_WORD_W   = 16;
   localparam int CLK_DIV_DEF  = 4;
   localparam int CS_SETUP_DEF = 2;
   localparam int CS_HOLD_DEF  = 2;
   localparam int CS_GAP_DEF   = 4;
   localparam int CNT_W        = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

endpackage

// File: rtl/spi_master16_sync2.sv
// Two-flop synchronizer for bringing an asynchronous input into the clk domain.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/spi_master16.sv
// Mode-0 SPI master moving one 16-bit word per start, MSB first.
// Define SPI_MASTER_LOOPBACK_EN to feed the rx shifter from the internal mosi bit.
module spi_master16
   import spi_pkg::*;
#(
   parameter int CLK_DIV      = CLK_DIV_DEF,
   parameter int CS_SETUP_CYC = CS_SETUP_DEF,
   parameter int CS_HOLD_CYC  = CS_HOLD_DEF,
   parameter int CS_GAP_CYC   = CS_GAP_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SPI_WORD_W-1:0] tx_data,
   output logic                  busy,
   output logic                  done,
   output logic [SPI_WORD_W-1:0] rx_data,
   output logic                  cs_n,
   output logic                  sck,
   output logic                  mosi,
   input  logic                  miso
);

   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_CYC - 1);

   spi_state_e            state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [4:0]            bit_q;
   logic [SPI_WORD_W-2:0] tx_sh_q;
   logic [SPI_WORD_W-1:0] rx_sh_q;
   logic [SPI_WORD_W-1:0] rx_data_q;
   logic                  cs_n_q, sck_q, mosi_q, busy_q, done_q;
   logic                  arm_q;
   logic                  miso_s;
   logic                  rx_in;

   sync2 u_miso_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (miso),
      .q_o   (miso_s)
   );

`ifdef SPI_MASTER_LOOPBACK_EN
   logic unused_miso_s;
   assign unused_miso_s = miso_s;
   assign rx_in         = mosi_q;
`else
   assign rx_in = miso_s;
`endif

   // arm_q keeps the first edge after reset release from accepting a start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         arm_q     <= 1'b0;
      end else begin
         arm_q  <= 1'b1;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && arm_q) begin
                  tx_sh_q <= tx_data[SPI_WORD_W-2:0];
                  mosi_q  <= tx_data[SPI_WORD_W-1];
                  cs_n_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= ST_SHIFT;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q <= '0;
                  sck_q <= ~sck_q;
                  if (!sck_q) begin
                     rx_sh_q <= {rx_sh_q[SPI_WORD_W-2:0], rx_in};
                  end else if (bit_q == 5'd15) begin
                     state_q <= ST_HOLD;
                  end else begin
                     // mosi only moves on the falling sck edge
                     bit_q   <= bit_q + 5'd1;
                     mosi_q  <= tx_sh_q[SPI_WORD_W-2];
                     tx_sh_q <= {tx_sh_q[SPI_WORD_W-3:0], 1'b0};
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_q     <= '0;
                  cs_n_q    <= 1'b1;
                  rx_data_q <= rx_sh_q;
                  done_q    <= 1'b1;
                  state_q   <= ST_GAP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign cs_n    = cs_n_q;
   assign sck     = sck_q;
   assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master16.sv
// Scoreboard bench for spi_master16: slave model on miso, mosi/rx checked per done.
`timescale 1ns/1ps
module tb_spi_master16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] tx_data = 16'h0;
   logic        busy, done, cs_n, sck, mosi, miso;
   logic [15:0] rx_data;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] exp_tx[$];
   logic [15:0] exp_rx[$];
   logic [15:0] sl_q[$];
   logic [15:0] sl_sh  = 16'h0;
   logic [15:0] mon_sh = 16'h0;
   int          mon_cnt  = 0;
   int          done_cnt = 0;

   spi_master16 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .tx_data (tx_data),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .cs_n    (cs_n),
      .sck     (sck),
      .mosi    (mosi),
      .miso    (miso)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Slave loads its word on cs_n falling; monitor samples mosi on each sck rise.
   always @(negedge cs_n or posedge sck) begin
      if (sck) begin
         mon_sh  = {mon_sh[14:0], mosi};
         mon_cnt = mon_cnt + 1;
      end else begin
         sl_sh   = (sl_q.size() > 0) ? sl_q.pop_front() : 16'h0;
         mon_cnt = 0;
      end
   end

`ifdef SPI_MASTER_LOOPBACK_EN
   assign miso = 1'b0;
`else
   assign miso = (mon_cnt < 16) ? sl_sh[4'(15 - mon_cnt)] : 1'b0;
`endif

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (exp_rx.size() == 0) chk("sb_empty_on_done", 0, 1);
         else begin
            chk("rx_data", rx_data, exp_rx.pop_front());
            chk("mosi_word", mon_sh, exp_tx.pop_front());
            chk("sck_rises", mon_cnt, 16);
         end
      end
   end

   task automatic push(input logic [15:0] tx, input logic [15:0] sw);
      exp_tx.push_back(tx);
`ifdef SPI_MASTER_LOOPBACK_EN
      exp_rx.push_back(tx);
`else
      exp_rx.push_back(sw);
`endif
      sl_q.push_back(sw);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || !cs_n) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk(tag, 0, 1);
   endtask

   task automatic do_xfer(input logic [15:0] tx, input logic [15:0] sw);
      push(tx, sw);
      tx_data = tx;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      wait_idle("xfer_timeout");
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fr, bf, d, lows, gap, d2, n;
      bit started2;

      repeat (3) @(negedge clk);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sck", sck, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rx_data", rx_data, 16'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single transfer with cycle-accurate timing
      push(16'hA55A, 16'h53F0);
      tx_data = 16'hA55A;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk("cs_fall_c1", cs_n, 0);
      chk("busy_c1", busy, 1);
      chk("mosi_msb_c1", mosi, 1);
      fr = 0; bf = 0; d = 0;
      for (int k = 1; k < 300; k++) begin
         if (sck && fr == 0) fr = k;
         if (done) d++;
         if (!busy) begin
            bf = k;
            break;
         end
         @(negedge clk);
      end
      chk("first_sck_rise_cycle", fr, 7);
      chk("busy_fall_cycle", bf, 137);
      chk("single_done_pulses", d, 1);

      // start pulse and tx_data change mid-transfer must be ignored
      push(16'h3C3C, 16'hC3C3);
      tx_data = 16'h3C3C;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      repeat (49) @(negedge clk);
      tx_data = 16'hFFFF;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      tx_data = 16'h0000;
      wait_idle("ign_timeout");
      lows = 0;
      for (int k = 0; k < 20; k++) begin
         if (!cs_n) lows++;
         @(negedge clk);
      end
      chk("ignored_no_extra_frame", lows, 0);

      // back-to-back with start held high
      push(16'h0001, 16'h1357);
      push(16'h8000, 16'h2468);
      tx_data = 16'h0001;
      start   = 1'b1;
      @(negedge clk);
      tx_data = 16'h8000;
      gap = 0; d2 = 0; started2 = 1'b0; n = 0;
      while (n < 600) begin
         if (done) d2++;
         if (d2 >= 1 && !started2) begin
            if (cs_n) gap++;
            else begin
               started2 = 1'b1;
               start    = 1'b0;
            end
         end
         if (started2 && d2 == 2 && !busy) break;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("b2b_timeout", n < 600, 1);
      chk("b2b_gap_ge4", gap >= 4, 1);
      chk("b2b_done_pulses", d2, 2);

      // reset after the 7th sck rise, then restart
      push(16'h1111, 16'h2222);
      tx_data = 16'h1111;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (mon_cnt < 7 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_reach7", mon_cnt, 7);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_cs_n", cs_n, 1);
      chk("rst_mid_sck", sck, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_mosi", mosi, 0);
      chk("rst_mid_rx_data", rx_data, 16'h0);
      exp_tx.delete();
      exp_rx.delete();
      d = done_cnt;
      repeat (3) @(negedge clk);
      push(16'hFFFF, 16'h0F0F);
      rst_n   = 1'b1;
      tx_data = 16'hFFFF;
      start   = 1'b1;
      @(negedge clk);
      chk("no_accept_edge1", cs_n, 1);
      @(negedge clk);
      chk("accept_edge2", cs_n, 0);
      start = 1'b0;
      chk("rst_no_done", done_cnt, d);
      wait_idle("post_rst_timeout");

      do_xfer(16'h1234, 16'h0000);
      for (int i = 0; i < 3; i++) do_xfer(16'($urandom), 16'($urandom));

      repeat (5) @(negedge clk);
      chk("sb_drained", exp_rx.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
